// File: rtl/i2s_tx_sample_sched.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_tx_sample_sched
//  Purpose  : Sample scheduler for a left-justified I2S slave transmitter.
//             Buffers stereo pairs from a producer in a small FIFO and
//             presents one pair per lrclk frame on left_chan/right_chan.
//             Detects underruns, substitutes silence and counts the events.
//             Owns the transmitter prescaler, which is frozen outside IDLE.
//             Everything runs in the sclk domain.
//  Ports    :
//    sclk          in   bit clock, all logic on its rising edge
//    rst_n         in   asynchronous active-low reset
//    enable        in   1 = run, 0 = drain remaining samples then idle
//    cfg_prescaler in   prescaler value, sampled only while idle
//    lrclk         in   frame clock from the master (0 = left, 1 = right)
//    in_valid      in   producer offers a stereo pair
//    in_ready      out  FIFO accepts a pair this cycle
//    in_left       in   left sample
//    in_right      in   right sample
//    left_chan     out  left sample to the transmitter
//    right_chan    out  right sample to the transmitter
//    prescaler     out  prescaler to the transmitter
//    running       out  scheduler is in RUN
//    underrun      out  sticky underrun flag, cleared on entering IDLE
//    underrun_cnt  out  saturating underrun count, cleared on entering IDLE
//    fifo_level    out  FIFO occupancy in stereo pairs
//  Revision : 1.0  initial release
// ============================================================================
module i2s_tx_sample_sched #(
  parameter int AUDIO_DW = 32,
  parameter int FIFO_AW  = 2,
  parameter int UCNT_W   = 16
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [AUDIO_DW-1:0] cfg_prescaler,
  input  logic                lrclk,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AUDIO_DW-1:0] in_left,
  input  logic [AUDIO_DW-1:0] in_right,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic [AUDIO_DW-1:0] prescaler,
  output logic                running,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_cnt,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam int                DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  LEVEL_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [AUDIO_DW-1:0] PRESC_RST = AUDIO_DW'(AUDIO_DW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        lr_q;
  logic [FIFO_AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]            level_q;
  logic [2*AUDIO_DW-1:0]       mem_q [DEPTH];
  logic [AUDIO_DW-1:0]         left_q, right_q, presc_q;
  logic                        underrun_q;
  logic [UCNT_W-1:0]           ucnt_q;

  logic                        frame_start;
  logic                        fifo_empty;
  logic                        push, pop;
  logic                        flush;      // discard FIFO and clear underrun state
  logic                        zero_out;   // load silence into the outputs
  logic                        ur_hit;     // underrun event this frame

  // Falling edge of lrclk marks the start of the left half of a frame.
  assign frame_start = lr_q & ~lrclk;
  assign fifo_empty  = (level_q == '0);

  assign in_ready = (state_q != S_IDLE) && (level_q < LEVEL_MAX);
  // A push coinciding with a transition into IDLE is discarded with the flush.
  assign push     = in_valid & in_ready & ~flush;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      lr_q    <= lrclk;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    flush    = 1'b0;
    zero_out = 1'b0;
    ur_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        flush    = 1'b1;
        zero_out = 1'b1;
        if (enable) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (!enable) begin
          state_d  = S_IDLE;
          flush    = 1'b1;
          zero_out = 1'b1;
        end else if (frame_start && !fifo_empty) begin
          pop     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (frame_start) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else if (!enable) begin
            // Drain finished: the stop request only takes effect once the
            // FIFO is empty, so buffered samples are never lost.
            state_d  = S_IDLE;
            flush    = 1'b1;
            zero_out = 1'b1;
          end else begin
            zero_out = 1'b1;
            ur_hit   = 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        flush    = 1'b1;
        zero_out = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; pointers define validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output sample registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
    end else if (zero_out) begin
      left_q  <= '0;
      right_q <= '0;
    end else if (pop) begin
      {left_q, right_q} <= mem_q[rd_ptr_q];
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler: tracks the configuration only while idle
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= PRESC_RST;
    end else if (state_q == S_IDLE) begin
      presc_q <= cfg_prescaler;
    end
  end

  // --------------------------------------------------------------------------
  // Underrun flag and saturating counter
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else if (flush) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else if (ur_hit) begin
      underrun_q <= 1'b1;
      if (ucnt_q != {UCNT_W{1'b1}}) begin
        ucnt_q <= ucnt_q + 1'b1;
      end
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign prescaler    = presc_q;
  assign running      = (state_q == S_RUN);
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;
  assign fifo_level   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_sample_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_tx_sample_sched
//  Purpose  : Self-checking bench for i2s_tx_sample_sched. A queue-based
//             model tracks the expected outputs every cycle; directed
//             literal checks pin the model at key points. A second instance
//             with a 2-bit underrun counter exercises saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2s_tx_sample_sched;

  logic        sclk     = 1'b0;
  logic        rst_n    = 1'b1;
  logic        enable   = 1'b0;
  logic        lrclk    = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] cfg      = 32'd32;
  logic [31:0] in_left  = '0;
  logic [31:0] in_right = '0;

  wire         in_ready, running, underrun;
  wire  [31:0] left_chan, right_chan, prescaler;
  wire  [15:0] underrun_cnt;
  wire  [2:0]  fifo_level;

  wire         s_in_ready, s_running, s_underrun;
  wire  [31:0] s_left, s_right, s_presc;
  wire  [1:0]  s_cnt;
  wire  [2:0]  s_level;

  always #5 sclk = ~sclk;

  i2s_tx_sample_sched #(.AUDIO_DW(32), .FIFO_AW(2), .UCNT_W(16)) dut (
    .sclk(sclk), .rst_n(rst_n), .enable(enable), .cfg_prescaler(cfg),
    .lrclk(lrclk), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .left_chan(left_chan),
    .right_chan(right_chan), .prescaler(prescaler), .running(running),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  i2s_tx_sample_sched #(.AUDIO_DW(32), .FIFO_AW(2), .UCNT_W(2)) dut_sat (
    .sclk(sclk), .rst_n(rst_n), .enable(enable), .cfg_prescaler(cfg),
    .lrclk(lrclk), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_left(in_left), .in_right(in_right), .left_chan(s_left),
    .right_chan(s_right), .prescaler(s_presc), .running(s_running),
    .underrun(s_underrun), .underrun_cnt(s_cnt), .fifo_level(s_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: mode 0 = idle, 1 = filling, 2 = running
  // --------------------------------------------------------------------------
  int          m_mode = 0;
  logic [63:0] q[$];
  logic        m_lrq = 1'b1;
  logic [31:0] m_l = '0, m_r = '0, m_p = 32'd32;
  logic        m_ur = 1'b0;
  int          m_cnt = 0;
  logic        m_fs, m_psh, m_go_idle;

  function automatic logic m_ready();
    return (m_mode != 0) && (q.size() < 4);
  endfunction

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; q.delete(); m_lrq = 1'b1;
      m_l = '0; m_r = '0; m_p = 32'd32; m_ur = 1'b0; m_cnt = 0;
    end else begin
      m_fs      = m_lrq & ~lrclk;
      m_lrq     = lrclk;
      m_psh     = in_valid && m_ready();
      m_go_idle = 1'b0;
      if (m_mode == 0) begin
        m_p = cfg;
        if (enable) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!enable) m_go_idle = 1'b1;
        else if (m_fs && q.size() > 0) begin
          {m_l, m_r} = q.pop_front();
          m_mode = 2;
        end
      end else if (m_fs) begin
        if (q.size() > 0) {m_l, m_r} = q.pop_front();
        else if (!enable) m_go_idle = 1'b1;
        else begin
          m_l = '0; m_r = '0; m_ur = 1'b1; m_cnt++;
        end
      end
      if (m_go_idle) begin
        m_mode = 0; q.delete(); m_l = '0; m_r = '0; m_ur = 1'b0; m_cnt = 0;
      end else if (m_psh) begin
        q.push_back({in_left, in_right});
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge sclk) begin
    chk("c_left",   left_chan,  m_l);
    chk("c_right",  right_chan, m_r);
    chk("c_presc",  prescaler,  m_p);
    chk("c_run",    running,    m_mode == 2);
    chk("c_ur",     underrun,   m_ur);
    chk("c_cnt",    underrun_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("c_level",  fifo_level, q.size());
    chk("c_ready",  in_ready,   m_ready());
    chk("c_s_cnt",  s_cnt,      (m_cnt > 3) ? 3 : m_cnt);
    chk("c_s_left", {s_left, s_right}, {m_l, m_r});
    chk("c_s_misc", {s_presc, s_running, s_underrun, s_level, s_in_ready},
        {m_p, (m_mode == 2), m_ur, 3'(q.size()), m_ready()});
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
    int n;
    in_left = l; in_right = r; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready stayed 0 expected 1");
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic frame();
    lrclk = 1'b0; tick(8);
    lrclk = 1'b1; tick(8);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    chk("lit_rst_left",  left_chan, 0);
    chk("lit_rst_presc", prescaler, 32);
    chk("lit_rst_run",   running, 0);
    chk("lit_rst_ready", in_ready, 0);
    chk("lit_rst_level", fifo_level, 0);

    // Reset and start
    rst_n = 1'b1; tick(1);
    enable = 1'b1; tick(1);
    push_pair(32'h11111111, 32'h22222222);
    chk("lit_lvl1", fifo_level, 1);
    frame();
    chk("lit_first_l", left_chan, 32'h11111111);
    chk("lit_first_r", right_chan, 32'h22222222);
    chk("lit_first_run", running, 1);
    chk("lit_first_ur", underrun, 0);

    // FIFO full with a held fifth pair
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_left = 32'hA0000000 + i; in_right = 32'hB0000000 + i;
      tick(1);
    end
    in_left = 32'hA0000004; in_right = 32'hB0000004;
    tick(1);
    chk("lit_full_ready", in_ready, 0);
    chk("lit_full_level", fifo_level, 4);
    tick(2);
    chk("lit_held_level", fifo_level, 4);
    lrclk = 1'b0; tick(1);
    chk("lit_pop_left", left_chan, 32'hA0000000);
    chk("lit_pop_level", fifo_level, 3);
    tick(1);
    chk("lit_refill", fifo_level, 4);
    in_valid = 1'b0;
    tick(6); lrclk = 1'b1; tick(8);
    for (int i = 1; i <= 4; i++) begin
      frame();
      chk("lit_drain_l", left_chan, 32'hA0000000 + i);
    end

    // Underruns and saturation
    repeat (3) frame();
    chk("lit_ur_left", left_chan, 0);
    chk("lit_ur_flag", underrun, 1);
    chk("lit_ur_cnt3", underrun_cnt, 3);
    chk("lit_sat_cnt3", s_cnt, 3);
    repeat (3) frame();
    chk("lit_ur_cnt6", underrun_cnt, 6);
    chk("lit_sat_hold", s_cnt, 3);
    push_pair(32'hAAAA0000, 32'h0000AAAA);
    frame();
    chk("lit_aa_l", left_chan, 32'hAAAA0000);
    chk("lit_aa_r", right_chan, 32'h0000AAAA);
    chk("lit_aa_ur", underrun, 1);

    // Drain on disable
    push_pair(32'hC1C1C1C1, 32'h1C1C1C1C);
    push_pair(32'hC2C2C2C2, 32'h2C2C2C2C);
    enable = 1'b0; cfg = 32'd64;
    frame();
    chk("lit_dr1", left_chan, 32'hC1C1C1C1);
    chk("lit_dr_presc", prescaler, 32);
    frame();
    chk("lit_dr2", right_chan, 32'h2C2C2C2C);
    chk("lit_dr2_run", running, 1);
    frame();
    chk("lit_idle_run", running, 0);
    chk("lit_idle_left", left_chan, 0);
    chk("lit_idle_cnt", underrun_cnt, 0);
    chk("lit_idle_ur", underrun, 0);
    chk("lit_idle_presc", prescaler, 64);

    // Asynchronous reset mid-RUN
    enable = 1'b1; tick(2);
    push_pair(32'hD1D1D1D1, 32'h1D1D1D1D);
    frame();
    chk("lit_d1", left_chan, 32'hD1D1D1D1);
    push_pair(32'hD2D2D2D2, 32'h2D2D2D2D);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_ar_left",  left_chan, 0);
    chk("lit_ar_presc", prescaler, 32);
    chk("lit_ar_run",   running, 0);
    chk("lit_ar_level", fifo_level, 0);
    chk("lit_ar_ready", in_ready, 0);
    tick(2);
    rst_n = 1'b1; tick(2);
    chk("lit_refill_run",   running, 0);
    chk("lit_refill_ready", in_ready, 1);
    push_pair(32'hE1E1E1E1, 32'h1E1E1E1E);
    frame();
    chk("lit_e1", left_chan, 32'hE1E1E1E1);
    chk("lit_e1_run", running, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_tx_sample_sched.md
Name: i2s_tx_sample_sched

Overview:
- Sequences stereo samples into the left-justified I2S slave transmitter.
- Accepts stereo words from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Presents one stereo pair per lrclk frame on the transmitter's left_chan/right_chan inputs and owns the transmitter's prescaler configuration.
- Detects underruns, substitutes silence, and counts the events.
- Runs entirely in the sclk domain, between the audio DMA/mixer and the transmitter.

Parameters:
- AUDIO_DW, 32, sample width per channel; also the width of prescaler.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW stereo pairs.
- UCNT_W, 16, width of the saturating underrun counter.

Ports:
- sclk  in  1  bit clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run, 0 = drain to idle.
- cfg_prescaler  in  AUDIO_DW  sclk cycles per channel, applied only while idle.
- lrclk  in  1  frame clock from the external master (0 = left half, 1 = right half).
- in_valid  in  1  producer has a stereo pair.
- in_ready  out  1  FIFO can accept a pair.
- in_left  in  AUDIO_DW  left sample.
- in_right  in  AUDIO_DW  right sample.
- left_chan  out  AUDIO_DW  to transmitter.
- right_chan  out  AUDIO_DW  to transmitter.
- prescaler  out  AUDIO_DW  to transmitter.
- running  out  1  state is RUN.
- underrun  out  1  sticky; set on any underrun; cleared by entering IDLE.
- underrun_cnt  out  UCNT_W  saturating underrun count; cleared by entering IDLE.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0) values:
  - left_chan, right_chan = 0; prescaler = AUDIO_DW.
  - running = 0; underrun = 0; underrun_cnt = 0; fifo_level = 0; in_ready = 0.
  - State = IDLE; lr_q = 1; FIFO pointers = 0.
- Frame boundary detection:
  - lr_q <= lrclk every cycle.
  - frame_start = lr_q & ~lrclk, i.e. the falling edge of lrclk, which is the start of the left channel.
  - Outputs change only at frame_start, so they are stable long before the transmitter samples them at the lrclk rising edge.
- FIFO handshake:
  - in_ready = (state != IDLE) & (fifo_level < depth).
  - Push when in_valid & in_ready. in_left, in_right and in_valid must stay stable while in_valid=1 and in_ready=0.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Pointers wrap modulo depth. The level counter is one bit wider than the pointers, so full and empty are unambiguous.
- State IDLE:
  - Outputs are zero; prescaler <= cfg_prescaler every cycle; FIFO is flushed; underrun and underrun_cnt are cleared.
  - enable=1 -> FILL.
- State FILL:
  - Accept pushes; outputs stay zero.
  - At frame_start with fifo_level >= 1: pop into left_chan/right_chan (visible the next cycle), then -> RUN.
  - enable=0 -> IDLE.
- State RUN:
  - At each frame_start:
    - If the FIFO is non-empty, pop the head into the outputs.
    - If it is empty, load 0 into both outputs, set underrun, and increment underrun_cnt, saturating at all-ones.
  - Once enable=0 is seen, remaining frame_starts keep popping normally, with no underrun counted.
  - Transition to IDLE happens at the first frame_start that finds the FIFO empty after enable=0 was seen. Outputs become 0 at that point.
  - If enable returns to 1 before that point, the pending stop is cancelled and the block stays in RUN.
- Latency: output load is 1 sclk after the sclk edge that observes lrclk=0 following lrclk=1.
- Prescaler is frozen outside IDLE. cfg_prescaler changes there are ignored until the next IDLE.
- Reset asserted mid-frame: all state returns to reset values immediately, and FIFO contents are discarded.

Test Plan:
- Reset and start: enable=1, prescaler cfg 32, push (L=0x11111111, R=0x22222222).
  - At the first lrclk fall: left_chan=0x11111111, right_chan=0x22222222, running=1, underrun=0.
- FIFO full: push 5 pairs back-to-back with no frame_start (depth 4).
  - in_ready drops after the 4th push and fifo_level=4.
  - The 5th pair is held and accepted after the next frame_start pop.
- Underrun: in RUN with the FIFO empty, 3 frame_starts occur.
  - Outputs = 0, underrun=1, underrun_cnt=3.
  - Then push 0xAAAA0000/0x0000AAAA: outputs take these values at the next frame_start, and underrun stays 1.
- Saturation: UCNT_W=2, 6 underruns -> underrun_cnt=3.
- Drain on disable: FIFO holds 2 pairs, then enable=0.
  - The next two frame_starts output those pairs.
  - The third frame_start -> IDLE, outputs 0, underrun_cnt=0, prescaler tracks cfg_prescaler=64.
- Async reset mid-RUN: rst_n=0 between sclk edges.
  - All outputs go to reset values immediately, including prescaler=AUDIO_DW.
  - After release with enable=1, the block re-enters FILL.
